// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, flag positions, mul/div opcodes
// and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/alu.sv
// Execute-stage ALU. On subtract the carry flag reports a borrow (1 = a < b).
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      ctrl_i,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      flags_o
);
    import alu_pkg::*;

    logic            sub_s;
    logic            arith_s;
    logic [XLEN-1:0] b_eff_s;
    logic [XLEN:0]   sum_s;

    // Result and {N,Z,C,V} flag generation
    always_comb begin
        sub_s    = (ctrl_i == ALU_SUB);
        arith_s  = (ctrl_i == ALU_ADD) || (ctrl_i == ALU_SUB);
        b_eff_s  = sub_s ? ~b_i : b_i;
        sum_s    = {1'b0, a_i} + {1'b0, b_eff_s} + {{XLEN{1'b0}}, sub_s};
        flags_o  = 4'b0000;
        case (ctrl_i)
            ALU_ADD: result_o = sum_s[XLEN-1:0];
            ALU_SUB: result_o = sum_s[XLEN-1:0];
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: result_o = {XLEN{1'b0}};
        endcase
        flags_o[FLAG_N] = result_o[XLEN-1];
        flags_o[FLAG_Z] = (result_o == {XLEN{1'b0}});
        if (arith_s) begin
            flags_o[FLAG_C] = sub_s ? ~sum_s[XLEN] : sum_s[XLEN];
            flags_o[FLAG_V] = (a_i[XLEN-1] == b_eff_s[XLEN-1]) &&
                              (result_o[XLEN-1] != a_i[XLEN-1]);
        end else begin
            flags_o[FLAG_C] = 1'b0;
            flags_o[FLAG_V] = 1'b0;
        end
    end

endmodule

// File: rtl/md_iter_step.sv
// One shift-add multiply or restoring-divide iteration: picks the ALU operands
// and folds the ALU result back into the accumulator/shift registers.
module md_iter_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_carry_i,
    output logic [3:0]      alu_ctrl_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [XLEN-1:0] acc_next_o,
    output logic [XLEN-1:0] lo_next_o
);
    import alu_pkg::*;

    logic [XLEN-1:0] shifted_s;
    logic            take_s;

    // Operand select and next register values for the current iteration
    always_comb begin
        shifted_s  = {acc_i[XLEN-2:0], lo_i[XLEN-1]};
        // The bit shifted out of rem means the true value exceeds any divisor
        take_s     = acc_i[XLEN-1] | ~alu_carry_i;
        alu_ctrl_o = ALU_ADD;
        op1_o      = acc_i;
        op2_o      = {XLEN{1'b0}};
        acc_next_o = acc_i;
        lo_next_o  = lo_i;
        if (is_div_i) begin
            alu_ctrl_o = ALU_SUB;
            op1_o      = shifted_s;
            op2_o      = opb_i;
            acc_next_o = take_s ? alu_result_i : shifted_s;
            lo_next_o  = {lo_i[XLEN-2:0], take_s};
        end else begin
            alu_ctrl_o = ALU_ADD;
            op1_o      = acc_i;
            op2_o      = lo_i[0] ? opb_i : {XLEN{1'b0}};
            acc_next_o = {alu_carry_i, alu_result_i[XLEN-1:1]};
            lo_next_o  = {alu_result_i[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned mul/div sequencer that borrows the execute-stage ALU,
// one add/sub per cycle, stalling the pipeline until its result is ready.
module alu_muldiv_seq #(
    parameter int XLEN   = 32,
    parameter int ITER   = XLEN,
    parameter int FLAG_C = alu_pkg::FLAG_C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic [1:0]      MdOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] MdResultE,
    output logic            MdOwnsALU,
    output logic [3:0]      MdALUControl,
    output logic [XLEN-1:0] MdOp1,
    output logic [XLEN-1:0] MdOp2,
    input  logic [XLEN-1:0] ALUResultIn,
    input  logic [3:0]      ALUFlagsIn
);
    import alu_pkg::*;

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e       state_q, state_d;
    md_op_e          op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_div_s;
    logic [3:0]      step_ctrl_s;
    logic [XLEN-1:0] step_op1_s, step_op2_s, step_acc_s, step_lo_s;
    logic [XLEN-1:0] final_s;
    logic            unused_flags_s;

    assign is_div_s       = (op_q == MD_DIVU) || (op_q == MD_REMU);
    assign unused_flags_s = ^ALUFlagsIn;

    md_iter_step #(.XLEN(XLEN)) u_step (
        .is_div_i     (is_div_s),
        .acc_i        (acc_q),
        .lo_i         (lo_q),
        .opb_i        (opb_q),
        .alu_result_i (ALUResultIn),
        .alu_carry_i  (ALUFlagsIn[FLAG_C]),
        .alu_ctrl_o   (step_ctrl_s),
        .op1_o        (step_op1_s),
        .op2_o        (step_op2_s),
        .acc_next_o   (step_acc_s),
        .lo_next_o    (step_lo_s)
    );

    // Final result selection: lo/quo share one register, hi/rem the other
    always_comb begin
        case (op_q)
            MD_MUL:   final_s = lo_q;
            MD_MULHU: final_s = acc_q;
            MD_DIVU:  final_s = lo_q;
            MD_REMU:  final_s = acc_q;
            default:  final_s = {XLEN{1'b0}};
        endcase
    end

    // State, datapath and output control
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        lo_d         = lo_q;
        opb_d        = opb_q;
        result_d     = result_q;
        BusyE        = 1'b0;
        DoneE        = 1'b0;
        MdOwnsALU    = 1'b0;
        MdResultE    = result_q;
        case (state_q)
            ST_IDLE: begin
                BusyE = StartE;
                if (FlushE) begin
                    state_d = ST_IDLE;
                end else if (StartE) begin
                    op_d    = md_op_e'(MdOpE);
                    acc_d   = {XLEN{1'b0}};
                    lo_d    = SrcAE;
                    opb_d   = SrcBE;
                    cnt_d   = CW'(ITER - 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                BusyE     = 1'b1;
                MdOwnsALU = 1'b1;
                if (FlushE) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = step_acc_s;
                    lo_d    = step_lo_s;
                    cnt_d   = cnt_q - CW'(1);
                    state_d = (cnt_q == {CW{1'b0}}) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (FlushE) begin
                    DoneE = 1'b0;
                end else begin
                    DoneE     = 1'b1;
                    result_d  = final_s;
                    MdResultE = final_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        MdALUControl = MdOwnsALU ? step_ctrl_s : 4'b0000;
        MdOp1        = MdOwnsALU ? step_op1_s : {XLEN{1'b0}};
        MdOp2        = MdOwnsALU ? step_op2_s : {XLEN{1'b0}};
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MUL;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            opb_q    <= {XLEN{1'b0}};
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Closed-loop bench: sequencer plus real ALU, checked every cycle against a
// timeline/arithmetic reference model, with directed literal cases.
module tb_alu_muldiv_seq;

    localparam int XLEN = 32;
    localparam int ITER = 32;

    logic            clk, reset, StartE, FlushE;
    logic [1:0]      MdOpE;
    logic [XLEN-1:0] SrcAE, SrcBE;
    logic            BusyE, DoneE, MdOwnsALU;
    logic [XLEN-1:0] MdResultE, MdOp1, MdOp2;
    logic [3:0]      MdALUControl;
    logic [XLEN-1:0] ALUResultIn;
    logic [3:0]      ALUFlagsIn;
    logic [XLEN-1:0] pipe_a, pipe_b, alu_a, alu_b;
    logic [3:0]      alu_ctrl;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    assign alu_a    = MdOwnsALU ? MdOp1 : pipe_a;
    assign alu_b    = MdOwnsALU ? MdOp2 : pipe_b;
    assign alu_ctrl = MdOwnsALU ? MdALUControl : 4'b0011;

    alu #(.XLEN(XLEN)) u_alu (
        .a_i(alu_a), .b_i(alu_b), .ctrl_i(alu_ctrl),
        .result_o(ALUResultIn), .flags_o(ALUFlagsIn)
    );

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .MdOpE(MdOpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
        .BusyE(BusyE), .DoneE(DoneE), .MdResultE(MdResultE),
        .MdOwnsALU(MdOwnsALU), .MdALUControl(MdALUControl),
        .MdOp1(MdOp1), .MdOp2(MdOp2),
        .ALUResultIn(ALUResultIn), .ALUFlagsIn(ALUFlagsIn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] op);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b11:   return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: phase 0 idle, 1..ITER run iteration k, ITER+1 done
    int          m_phase;
    logic [31:0] m_a, m_b, m_res;
    logic [1:0]  m_op;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_res <= 32'd0; m_a <= 32'd0; m_b <= 32'd0; m_op <= 2'b00;
        end else if (m_phase == 0) begin
            if (StartE && !FlushE) begin
                m_phase <= 1; m_a <= SrcAE; m_b <= SrcBE; m_op <= MdOpE;
            end
        end else if (m_phase <= ITER) begin
            m_phase <= FlushE ? 0 : m_phase + 1;
        end else begin
            if (!FlushE) m_res <= ref_result(m_a, m_b, m_op);
            m_phase <= 0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic        e_owns, e_busy, e_done, e_div;
        logic [31:0] e_op1, e_op2;
        logic [63:0] part, r;
        int          k;
        k      = m_phase;
        e_owns = (k >= 1) && (k <= ITER);
        e_busy = (k == 0) ? StartE : e_owns;
        e_done = (k == ITER + 1) && !FlushE;
        e_div  = m_op[1];
        e_op1  = 32'd0;
        e_op2  = 32'd0;
        if (e_owns && !e_div) begin
            part  = ({32'd0, m_b} * ({32'd0, m_a} & ((64'd1 << (k - 1)) - 64'd1))) >> (k - 1);
            e_op1 = part[31:0];
            e_op2 = m_a[k-1] ? m_b : 32'd0;
        end else if (e_owns) begin
            r     = {32'd0, m_a} >> (33 - k);
            if (m_b != 32'd0) r = r % {32'd0, m_b};
            r     = (r << 1) | {63'd0, m_a[32-k]};
            e_op1 = r[31:0];
            e_op2 = m_b;
        end
        chk("busy", {31'd0, BusyE}, {31'd0, e_busy});
        chk("done", {31'd0, DoneE}, {31'd0, e_done});
        chk("owns", {31'd0, MdOwnsALU}, {31'd0, e_owns});
        chk("result", MdResultE, e_done ? ref_result(m_a, m_b, m_op) : m_res);
        chk("aluctl", {28'd0, MdALUControl}, (e_owns && e_div) ? 32'd1 : 32'd0);
        chk("op1", MdOp1, e_op1);
        chk("op2", MdOp2, e_op2);
    end

    always @(posedge clk) begin
        #1;
        pipe_a = $urandom;
        pipe_b = $urandom;
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] exp, input string nm, input bit poke);
        int          s, lat;
        bit          seen;
        logic [31:0] res;
        @(posedge clk); #1;
        StartE = 1'b1; SrcAE = a; SrcBE = b; MdOpE = op; s = cyc;
        seen = 1'b0; lat = 0; res = 32'd0;
        @(posedge clk); #1;
        for (int i = 1; i <= 45 && !seen; i++) begin
            StartE = poke && (i == 5);
            SrcAE  = $urandom; SrcBE = $urandom; MdOpE = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (DoneE) begin
                seen = 1'b1; lat = cyc - s; res = MdResultE;
            end
            @(posedge clk); #1;
        end
        StartE = 1'b0;
        chk({nm, "_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_lat"}, lat, 32'd33);
        chk(nm, res, exp);
    endtask

    initial begin
        int s, dones;
        reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; MdOpE = 2'b00;
        SrcAE = 32'd0; SrcBE = 32'd0; pipe_a = 32'd0; pipe_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, BusyE}, 32'd0);
        chk("rst_result", MdResultE, 32'd0);
        chk("rst_op1", MdOp1, 32'd0);
        #3 reset = 1'b0;

        run_op(32'd7, 32'd6, 2'b00, 32'h0000_002A, "mul_7x6", 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE, "mulhu_ones", 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, "mul_ones", 1'b0);
        run_op(32'd100, 32'd7, 2'b10, 32'h0000_000E, "divu_100_7", 1'b0);
        run_op(32'd100, 32'd7, 2'b11, 32'h0000_0002, "remu_100_7", 1'b0);
        run_op(32'h8000_0000, 32'd3, 2'b10, 32'h2AAA_AAAA, "divu_msb", 1'b0);
        run_op(32'h8000_0000, 32'd3, 2'b11, 32'h0000_0002, "remu_msb", 1'b0);
        run_op(32'h0000_1234, 32'd0, 2'b10, 32'hFFFF_FFFF, "divu_zero", 1'b0);
        run_op(32'h0000_1234, 32'd0, 2'b11, 32'h0000_1234, "remu_zero", 1'b0);
        run_op(32'd7, 32'd6, 2'b00, 32'h0000_002A, "mul_start_ignored", 1'b1);
        run_op(32'h0000_1234, 32'd0, 2'b11, 32'h0000_1234, "remu_zero2", 1'b0);

        // Flush in RUN cycle 10
        @(posedge clk); #1;
        StartE = 1'b1; SrcAE = 32'd5; SrcBE = 32'd5; MdOpE = 2'b00; s = cyc;
        @(posedge clk); #1;
        StartE = 1'b0;
        while (cyc < s + 10) begin @(posedge clk); #1; end
        FlushE = 1'b1;
        @(posedge clk); #1;
        FlushE = 1'b0;
        #1;
        chk("flush_busy", {31'd0, BusyE}, 32'd0);
        chk("flush_owns", {31'd0, MdOwnsALU}, 32'd0);
        chk("flush_result", MdResultE, 32'h0000_1234);
        dones = 0;
        repeat (40) begin @(negedge clk); if (DoneE) dones++; end
        chk("flush_no_done", dones, 32'd0);

        // Asynchronous reset mid-RUN
        @(posedge clk); #1;
        StartE = 1'b1; SrcAE = 32'd9; SrcBE = 32'd9; MdOpE = 2'b01;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, BusyE}, 32'd0);
        chk("arst_done", {31'd0, DoneE}, 32'd0);
        chk("arst_owns", {31'd0, MdOwnsALU}, 32'd0);
        chk("arst_result", MdResultE, 32'd0);
        chk("arst_ctl", {28'd0, MdALUControl}, 32'd0);
        chk("arst_op1", MdOp1, 32'd0);
        chk("arst_op2", MdOp2, 32'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        run_op(32'd7, 32'd6, 2'b00, 32'h0000_002A, "mul_after_rst", 1'b0);

        // Randomized traffic, every cycle checked by the model
        for (int c = 0; c < 4000; c++) begin
            int sel;
            @(posedge clk); #1;
            StartE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 99) == 0);
            MdOpE  = 2'($urandom_range(0, 3));
            SrcAE  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 | $urandom : $urandom;
            sel    = $urandom_range(0, 7);
            if (sel == 0)      SrcBE = 32'd0;
            else if (sel < 3)  SrcBE = $urandom_range(1, 15);
            else               SrcBE = $urandom;
        end
        @(posedge clk); #1;
        StartE = 1'b0; FlushE = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
